// File: rtl/mc_control.sv
// mc_control: multi-cycle main control FSM for the MISR2000 CPU
module mc_control #(
    parameter logic [5:0] ADD_OP = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Neg,
    input  logic       mem_ready,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       Byte,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [5:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, IEXEC = 4'd10, IWB = 4'd11
    } state_t;

    localparam logic [5:0] RTYPE = 6'b000000, LW = 6'b100011, LB = 6'b100000,
                           SW = 6'b101011, SB = 6'b101000, BEQ = 6'b000100,
                           BNE = 6'b000101, BLE = 6'b111010, BGT = 6'b111011,
                           JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100,
                           ORI = 6'b001101, SLTI = 6'b001010, XORI = 6'b001110;

    state_t cur, nxt;
    logic   is_mem, is_br, is_imm, taken;

    assign state  = cur;
    assign is_mem = Opcode inside {LW, LB, SW, SB};
    assign is_br  = Opcode inside {BEQ, BNE, BLE, BGT};
    assign is_imm = Opcode inside {ADDI, ANDI, ORI, SLTI, XORI};
    assign taken  = (Opcode == BEQ) ? Zero :
                    (Opcode == BNE) ? !Zero :
                    (Opcode == BLE) ? (Zero | Neg) : (!Zero & !Neg);

    // state register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= FETCH;
        else     cur <= nxt;
    end

    // next state and datapath controls; write enables are masked while in reset
    always_comb begin
        nxt      = cur;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Byte     = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 6'b000000;
        PCSource = 2'b00;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = ADD_OP;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = ADD_OP;
                nxt     = (Opcode == RTYPE) ? REXEC :
                          is_mem ? MEMADR :
                          is_br ? BRANCH :
                          (Opcode == JMP) ? JUMP :
                          is_imm ? IEXEC : FETCH;
                illegal = !((Opcode == RTYPE) || is_mem || is_br || (Opcode == JMP) || is_imm);
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = Opcode;
                nxt     = (Opcode == LW || Opcode == LB) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                Byte    = (Opcode == LB);
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = FETCH;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                Byte     = (Opcode == SB);
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                nxt     = RWB;
            end
            RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                nxt      = FETCH;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = Opcode;
                nxt     = IWB;
            end
            IWB: begin
                RegWrite = 1'b1;
                nxt      = FETCH;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = Opcode;
                PCSource = 2'b01;
                PCWrite  = taken;
                nxt      = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                nxt      = FETCH;
            end
            default: nxt = FETCH;
        endcase
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
        end
    end
endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-cycle vector bench for mc_control
module tb_mc_control;
    localparam logic [5:0] ADD = 6'b001000;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        n;
        logic        rdy;
        logic [3:0]  st;
        logic [20:0] ctl;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [5:0] Opcode = 6'd0;
    logic       Zero = 1'b0, Neg = 1'b0, mem_ready = 1'b1;
    logic       MemRead, MemWrite, Byte, IorD, IRWrite, PCWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [5:0] ALUOp;
    logic [3:0] state;
    logic [20:0] dut_ctl;
    int tests = 0, fails = 0;
    vec_t tv[$];

    mc_control dut (
        .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .Neg(Neg), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    assign dut_ctl = {MemRead, MemWrite, Byte, IorD, IRWrite, PCWrite, RegWrite, RegDst,
                      MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal};

    function automatic logic [20:0] c(input logic mr, mw, by, io, irw, pcw, rw, rd, m2r, asa,
                                      input logic [1:0] asb, input logic [5:0] aop,
                                      input logic [1:0] pcs, input logic ill);
        return {mr, mw, by, io, irw, pcw, rw, rd, m2r, asa, asb, aop, pcs, ill};
    endfunction

    function automatic vec_t v(input logic [5:0] op, input logic z, n, rdy,
                               input logic [3:0] st, input logic [20:0] ctl);
        vec_t r;
        r.op = op; r.z = z; r.n = n; r.rdy = rdy; r.st = st; r.ctl = ctl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        Opcode = t.op; Zero = t.z; Neg = t.n; mem_ready = t.rdy;
        #1;
        chk($sformatf("vec%0d state", idx), 32'(state), 32'(t.st));
        chk($sformatf("vec%0d ctl", idx), 32'(dut_ctl), 32'(t.ctl));
    endtask

    initial begin
        logic [20:0] f1, f0, dc;
        f1 = c(1,0,0,0,1,1,0,0,0,0,2'b01,ADD,2'b00,0);
        f0 = c(1,0,0,0,0,0,0,0,0,0,2'b01,ADD,2'b00,0);
        dc = c(0,0,0,0,0,0,0,0,0,0,2'b11,ADD,2'b00,0);
        // R-type add
        tv.push_back(v(6'b000000,0,0,1,4'd0,f1));
        tv.push_back(v(6'b000000,0,0,1,4'd1,dc));
        tv.push_back(v(6'b000000,0,0,0,4'd6,c(0,0,0,0,0,0,0,0,0,1,2'b00,6'b000000,2'b00,0)));
        tv.push_back(v(6'b000000,0,0,0,4'd7,c(0,0,0,0,0,0,1,1,0,0,2'b00,6'b000000,2'b00,0)));
        // lw with three stall cycles in MEMRD
        tv.push_back(v(6'b100011,0,0,1,4'd0,f1));
        tv.push_back(v(6'b100011,0,0,1,4'd1,dc));
        tv.push_back(v(6'b100011,0,0,0,4'd2,c(0,0,0,0,0,0,0,0,0,1,2'b10,6'b100011,2'b00,0)));
        tv.push_back(v(6'b100011,0,0,0,4'd3,c(1,0,0,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)));
        tv.push_back(v(6'b100011,0,0,0,4'd3,c(1,0,0,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)));
        tv.push_back(v(6'b100011,0,0,0,4'd3,c(1,0,0,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)));
        tv.push_back(v(6'b100011,0,0,1,4'd3,c(1,0,0,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)));
        tv.push_back(v(6'b100011,0,0,0,4'd4,c(0,0,0,0,0,0,1,0,1,0,2'b00,6'b000000,2'b00,0)));
        // sb, with one stall in FETCH first
        tv.push_back(v(6'b101000,0,0,0,4'd0,f0));
        tv.push_back(v(6'b101000,0,0,1,4'd0,f1));
        tv.push_back(v(6'b101000,0,0,1,4'd1,dc));
        tv.push_back(v(6'b101000,0,0,1,4'd2,c(0,0,0,0,0,0,0,0,0,1,2'b10,6'b101000,2'b00,0)));
        tv.push_back(v(6'b101000,0,0,1,4'd5,c(0,1,1,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)));
        // beq taken
        tv.push_back(v(6'b000100,0,0,1,4'd0,f1));
        tv.push_back(v(6'b000100,0,0,1,4'd1,dc));
        tv.push_back(v(6'b000100,1,0,1,4'd8,c(0,0,0,0,0,1,0,0,0,1,2'b00,6'b000100,2'b01,0)));
        // bgt not taken on negative
        tv.push_back(v(6'b111011,0,0,1,4'd0,f1));
        tv.push_back(v(6'b111011,0,0,1,4'd1,dc));
        tv.push_back(v(6'b111011,0,1,1,4'd8,c(0,0,0,0,0,0,0,0,0,1,2'b00,6'b111011,2'b01,0)));
        // ble taken on negative
        tv.push_back(v(6'b111010,0,0,1,4'd0,f1));
        tv.push_back(v(6'b111010,0,0,1,4'd1,dc));
        tv.push_back(v(6'b111010,0,1,1,4'd8,c(0,0,0,0,0,1,0,0,0,1,2'b00,6'b111010,2'b01,0)));
        // bne not taken on zero
        tv.push_back(v(6'b000101,0,0,1,4'd0,f1));
        tv.push_back(v(6'b000101,0,0,1,4'd1,dc));
        tv.push_back(v(6'b000101,1,0,0,4'd8,c(0,0,0,0,0,0,0,0,0,1,2'b00,6'b000101,2'b01,0)));
        // j
        tv.push_back(v(6'b000010,0,0,1,4'd0,f1));
        tv.push_back(v(6'b000010,0,0,0,4'd1,dc));
        tv.push_back(v(6'b000010,0,0,0,4'd9,c(0,0,0,0,0,1,0,0,0,0,2'b00,6'b000000,2'b10,0)));
        // addi
        tv.push_back(v(6'b001000,0,0,1,4'd0,f1));
        tv.push_back(v(6'b001000,0,0,1,4'd1,dc));
        tv.push_back(v(6'b001000,0,0,0,4'd10,c(0,0,0,0,0,0,0,0,0,1,2'b10,6'b001000,2'b00,0)));
        tv.push_back(v(6'b001000,0,0,0,4'd11,c(0,0,0,0,0,0,1,0,0,0,2'b00,6'b000000,2'b00,0)));
        // illegal opcode
        tv.push_back(v(6'b111111,0,0,1,4'd0,f1));
        tv.push_back(v(6'b111111,0,0,0,4'd1,c(0,0,0,0,0,0,0,0,0,0,2'b11,ADD,2'b00,1)));
        tv.push_back(v(6'b111111,0,0,0,4'd0,f0));

        // reset with ready high: enables must stay low
        #1;
        chk("reset state", 32'(state), 32'd0);
        chk("reset IRWrite/PCWrite", 32'({IRWrite, PCWrite}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("reset held state", 32'(state), 32'd0);
        rst = 1'b0;
        foreach (tv[i]) begin
            apply(tv[i], i);
            @(negedge clk);
        end

        // sw stalled in MEMWR, then reset mid-cycle
        apply(v(6'b101011,0,0,1,4'd0,f1), 100);
        @(negedge clk);
        apply(v(6'b101011,0,0,1,4'd1,dc), 101);
        @(negedge clk);
        apply(v(6'b101011,0,0,0,4'd2,c(0,0,0,0,0,0,0,0,0,1,2'b10,6'b101011,2'b00,0)), 102);
        @(negedge clk);
        apply(v(6'b101011,0,0,0,4'd5,c(0,1,0,1,0,0,0,0,0,0,2'b00,6'b000000,2'b00,0)), 103);
        #2;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("async reset state", 32'(state), 32'd0);
        chk("async reset MemWrite", 32'(MemWrite), 32'd0);
        chk("async reset enables", 32'({PCWrite, IRWrite, RegWrite}), 32'd0);
        @(negedge clk);
        chk("reset across edge state", 32'(state), 32'd0);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("release MemRead", 32'(MemRead), 32'd1);
        chk("release ALUOp", 32'(ALUOp), 32'(ADD));
        chk("release ALUSrcB", 32'(ALUSrcB), 32'd1);
        @(negedge clk);
        chk("release stall state", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
